cdc_fifo_write_arbiter: RTL and testbench

//  Shares the single write port of the CDC FIFO among NUM_REQ requesters.
//  - Runs in the FIFO write-clock domain: clk is tied to the FIFO write_clock.
//  - Round-robin grant with a bounded burst length per grant.
//  - Drives write_data/write_increment and honours full.
//  - Keeps a saturating count of full-stall cycles for debug.

---
 rtl/cdc_fifo_write_arbiter.sv | 101 ++++++++++
 tb/tb_cdc_fifo_write_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_write_arbiter.sv
// Round-robin arbiter that shares the CDC FIFO write port among NUM_REQ requesters.
// Runs in the FIFO write-clock domain, with bounded bursts and a full-stall counter.
module cdc_fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            full,
  output logic [DATA_WIDTH-1:0]           write_data,
  output logic                            write_increment,
  output logic                            busy,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [7:0]                      stall_count
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BURST_MAX + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]    state;
  logic [GW-1:0] grant;
  logic [CW-1:0] burst_cnt;
  logic [GW-1:0] next_grant;
  logic [GW-1:0] idx;
  logic          found;
  logic          accept;

  // Round-robin search starting just after the last grant.
  always_comb begin
    next_grant = grant;
    found      = 1'b0;
    idx        = grant;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx        = GW'((int'(grant) + k) % NUM_REQ);
      next_grant = (!found && req_valid[idx]) ? idx : next_grant;
      found      = found | req_valid[idx];
    end
  end

  // The write strobe follows full and reset in the same cycle: no registering.
  always_comb begin
    accept          = (state == ST_BUSY) & req_valid[grant] & ~full & ~reset;
    write_increment = accept;
    req_ready       = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant)
                             : {NUM_REQ{1'b0}};
    write_data      = (state == ST_BUSY) ? req_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH]
                                         : {DATA_WIDTH{1'b0}};
  end

  // Arbitration state, burst counting and saturating stall counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant       <= GW'(NUM_REQ - 1);
      burst_cnt   <= {CW{1'b0}};
      stall_count <= 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant     <= next_grant;
            burst_cnt <= {CW{1'b0}};
            state     <= ST_BUSY;
          end else begin
            state     <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (!req_valid[grant]) begin
            state <= ST_IDLE;
          end else if (full) begin
            if (stall_count != 8'hFF) begin
              stall_count <= stall_count + 8'd1;
            end else begin
              stall_count <= stall_count;
            end
          end else begin
            burst_cnt <= burst_cnt + CW'(1);
            if (burst_cnt == CW'(BURST_MAX - 1)) begin
              state <= ST_IDLE;
            end else begin
              state <= ST_BUSY;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = (state == ST_BUSY);
  assign grant_id = grant;

endmodule

// File: tb/tb_cdc_fifo_write_arbiter.sv
// Self-checking bench: directed table, corner sequences and a randomized run
// against a behavioural model; a second instance with BURST_MAX=2 covers rotation.
module tb_cdc_fifo_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_data;
  logic        full;
  logic [3:0]  req_ready, b2_ready;
  logic [3:0]  write_data, b2_wdata;
  logic        write_increment, b2_wi;
  logic        busy, b2_busy;
  logic [1:0]  grant_id, b2_grant;
  logic [7:0]  stall_count, b2_stall;

  always #5 clk = ~clk;

  cdc_fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .full(full), .write_data(write_data),
    .write_increment(write_increment), .busy(busy), .grant_id(grant_id),
    .stall_count(stall_count));

  cdc_fifo_write_arbiter #(.NUM_REQ(4), .DATA_WIDTH(4), .BURST_MAX(2)) dut_b2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(b2_ready), .full(full), .write_data(b2_wdata),
    .write_increment(b2_wi), .busy(b2_busy), .grant_id(b2_grant),
    .stall_count(b2_stall));

  int checks = 0;
  int errors = 0;

  // Snapshot of outputs taken mid-cycle
  logic       s_busy, s_wi, s2_busy, s2_wi;
  logic [1:0] s_grant, s2_grant;
  logic [3:0] s_wdata, s_ready, s2_wdata;
  logic [7:0] s_stall;

  // Behavioural model of the BURST_MAX=4 instance
  bit m_busy;
  int m_grant, m_cnt, m_stall;
  localparam int BM = 4;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit [3:0] v, input bit [15:0] d,
                      input bit f, input bit chk);
    bit acc;
    int p_wdata, p_ready, k, g;
    reset = r; req_valid = v; req_data = d; full = f;
    @(negedge clk);
    s_busy = busy; s_wi = write_increment; s_grant = grant_id;
    s_wdata = write_data; s_ready = req_ready; s_stall = stall_count;
    s2_busy = b2_busy; s2_wi = b2_wi; s2_grant = b2_grant; s2_wdata = b2_wdata;
    acc     = m_busy && v[m_grant] && !f && !r;
    p_wdata = m_busy ? int'(d[m_grant*4 +: 4]) : 0;
    p_ready = acc ? (1 << m_grant) : 0;
    if (chk) begin
      check("busy", int'(s_busy), int'(m_busy));
      check("grant_id", int'(s_grant), m_grant);
      check("write_increment", int'(s_wi), int'(acc));
      check("write_data", int'(s_wdata), p_wdata);
      check("req_ready", int'(s_ready), p_ready);
      check("stall_count", int'(s_stall), m_stall);
    end
    if (r) begin
      m_busy = 1'b0; m_grant = 3; m_cnt = 0; m_stall = 0;
    end else if (!m_busy) begin
      if (v != 4'd0) begin
        g = m_grant;
        for (k = 1; k <= 4; k++) if (v[(g + k) % 4]) break;
        m_grant = (g + k) % 4; m_cnt = 0; m_busy = 1'b1;
      end
    end else if (!v[m_grant]) begin
      m_busy = 1'b0;
    end else if (f) begin
      m_stall = (m_stall < 255) ? m_stall + 1 : 255;
    end else begin
      m_cnt++;
      if (m_cnt == BM) m_busy = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit        rst;
    bit [3:0]  valid;
    bit [15:0] data;
    bit        full;
    bit        e_busy;
    bit [1:0]  e_grant;
    bit        e_wi;
    bit [3:0]  e_wdata;
    bit [3:0]  e_ready;
    bit [7:0]  e_stall;
  } vec_t;

  vec_t tbl[12];
  bit   has_word[4];
  bit [3:0] word[4];

  initial begin
    int writes, w;
    bit [3:0] v;
    bit [15:0] d;
    // reset hold, single-requester burst, reset during a pending BUSY cycle
    tbl[0]  = '{1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[1]  = '{1'b1, 4'hF, 16'h0000, 1'b0, 1'b0, 2'd3, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[2]  = '{1'b0, 4'h1, 16'h000A, 1'b0, 1'b0, 2'd3, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[3]  = '{1'b0, 4'h1, 16'h000A, 1'b0, 1'b1, 2'd0, 1'b1, 4'hA, 4'h1, 8'd0};
    tbl[4]  = '{1'b0, 4'h1, 16'h000B, 1'b0, 1'b1, 2'd0, 1'b1, 4'hB, 4'h1, 8'd0};
    tbl[5]  = '{1'b0, 4'h1, 16'h000C, 1'b0, 1'b1, 2'd0, 1'b1, 4'hC, 4'h1, 8'd0};
    tbl[6]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b1, 2'd0, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[7]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[8]  = '{1'b0, 4'h2, 16'h0050, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[9]  = '{1'b1, 4'h2, 16'h0050, 1'b0, 1'b1, 2'd1, 1'b0, 4'h5, 4'h0, 8'd0};
    tbl[10] = '{1'b0, 4'h3, 16'h0056, 1'b0, 1'b0, 2'd3, 1'b0, 4'h0, 4'h0, 8'd0};
    tbl[11] = '{1'b0, 4'h3, 16'h0056, 1'b0, 1'b1, 2'd0, 1'b1, 4'h6, 4'h1, 8'd0};

    m_busy = 1'b0; m_grant = 3; m_cnt = 0; m_stall = 0;
    step(1'b1, 4'hF, 16'h0, 1'b0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].data, tbl[i].full, 1'b1);
      check("tbl_busy", int'(s_busy), int'(tbl[i].e_busy));
      check("tbl_grant", int'(s_grant), int'(tbl[i].e_grant));
      check("tbl_wi", int'(s_wi), int'(tbl[i].e_wi));
      check("tbl_wdata", int'(s_wdata), int'(tbl[i].e_wdata));
      check("tbl_ready", int'(s_ready), int'(tbl[i].e_ready));
      check("tbl_stall", int'(s_stall), int'(tbl[i].e_stall));
    end

    // Rotation on the BURST_MAX=2 instance: grants 0,1,2,3,0 with one bubble each
    step(1'b1, 4'hF, 16'h4321, 1'b0, 1'b1);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 4'hF, 16'h4321, 1'b0, 1'b1);
      if (k % 3 == 0) begin
        check("rr_busy", int'(s2_busy), 0);
        check("rr_grant", int'(s2_grant), (k / 3 + 3) % 4);
        check("rr_wi", int'(s2_wi), 0);
      end else begin
        check("rr_busy", int'(s2_busy), 1);
        check("rr_grant", int'(s2_grant), (k / 3) % 4);
        check("rr_wi", int'(s2_wi), 1);
        check("rr_wdata", int'(s2_wdata), (k / 3) % 4 + 1);
      end
    end

    // full for 3 cycles mid-burst of requester 1
    step(1'b1, 4'h0, 16'h0, 1'b0, 1'b1);
    writes = 0; w = 0;
    for (int c = 0; c < 9; c++) begin
      d = 16'h0; d[7:4] = 4'(w + 1);
      step(1'b0, 4'h2, d, (c >= 3 && c <= 5), 1'b1);
      if (s_wi) begin
        check("stall_burst_word", int'(s_wdata), w + 1);
        writes++;
      end
      if (c >= 3 && c <= 5) begin
        check("stall_ready", int'(s_ready), 0);
        check("stall_wi", int'(s_wi), 0);
        check("stall_held_word", int'(s_wdata), 3);
      end
      if (s_ready[1]) w++;
    end
    check("stall_burst_total", writes, 4);
    check("stall_count3", int'(s_stall), 3);
    check("stall_end_idle", int'(s_busy), 0);

    // 300 stalled BUSY cycles saturate the counter
    step(1'b1, 4'h0, 16'h0, 1'b0, 1'b1);
    for (int c = 0; c < 302; c++) begin
      step(1'b0, 4'h4, 16'h0700, 1'b1, 1'b1);
      if (c == 200) check("stall_mid", int'(s_stall), 199);
    end
    check("stall_saturated", int'(s_stall), 255);

    // Randomized traffic with requesters honouring the hold contract
    step(1'b1, 4'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) has_word[i] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!has_word[i] && ($urandom % 3 != 0)) begin
          has_word[i] = 1'b1; word[i] = 4'($urandom);
        end else if (has_word[i] && ($urandom % 20 == 0)) begin
          has_word[i] = 1'b0;
        end
        v[i] = has_word[i];
        d[i*4 +: 4] = has_word[i] ? word[i] : 4'($urandom);
      end
      step(($urandom % 100 == 0), v, d, ($urandom % 4 == 0), 1'b1);
      for (int i = 0; i < 4; i++) if (s_ready[i]) has_word[i] = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
